// File: rtl/cpu_clk_ctrl.sv
// ----------------------------------------------------------------------------
// cpu_clk_ctrl
//   Run/step/halt sequencer for the CPU clock. Samples one tap of the
//   free-running clkdiv counter (fast or slow) and turns its edges into a
//   registered, glitch-free Clk_CPU. Supports free-run, single-step from a
//   debounced push button, and halt on request. A CPU high phase is never cut
//   short: a stop that arrives while Clk_CPU is high drains until the tap falls.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   clkdiv     in   [31:0] free-running divider count
//   mode_sel   in   0 = FAST_TAP, 1 = SLOW_TAP
//   run        in   1 = free-run, 0 = step mode
//   step_btn   in   raw asynchronous, bouncing step button
//   halt_req   in   level halt request
//   Clk_CPU    out  registered CPU clock
//   cpu_tick   out  one-clk pulse on each Clk_CPU rising edge
//   state      out  [1:0] 0 HALT, 1 RUN, 2 STEP, 3 DRAIN
//   cycle_cnt  out  [31:0] number of Clk_CPU rising edges issued (wraps)
// ----------------------------------------------------------------------------
module cpu_clk_ctrl #(
    parameter int FAST_TAP = 1,
    parameter int SLOW_TAP = 24,
    parameter int DB_COUNT = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] clkdiv,
    input  logic        mode_sel,
    input  logic        run,
    input  logic        step_btn,
    input  logic        halt_req,
    output logic        Clk_CPU,
    output logic        cpu_tick,
    output logic [1:0]  state,
    output logic [31:0] cycle_cnt
);

    localparam int              DB_W    = $clog2(DB_COUNT);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_COUNT - 1);

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              clk_cpu_q, clk_cpu_d;
    logic              tick_q, tick_d;
    logic [31:0]       cycle_cnt_q, cycle_cnt_d;
    logic              mode_q, mode_d;
    logic              tap_q, tap_d;
    logic              sync1_q, sync2_q;
    logic              stable_q, stable_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              step_pulse_q, step_pulse_d;

    logic              tap, rise_ev, fall_ev, mode_upd;

    // Only two clkdiv bits are used; fold the rest into a sink.
    logic              unused_clkdiv;
    assign unused_clkdiv = ^clkdiv;

    // ------------------------------------------------------------------
    // Tap selection and mode latch
    // ------------------------------------------------------------------
    always_comb begin
        tap      = mode_q ? clkdiv[SLOW_TAP] : clkdiv[FAST_TAP];
        rise_ev  = tap & ~tap_q;
        fall_ev  = ~tap & tap_q;
        // Mode may only change while stopped or right as the CPU clock falls,
        // so a switch can never shorten the current high phase.
        mode_upd = (state_q == ST_HALT) | ((state_q == ST_RUN) & fall_ev);
        mode_d   = mode_upd ? mode_sel : mode_q;
        // Load tap_q from the tap of the mode in effect next cycle; when the
        // mode changes this suppresses a spurious edge from the tap swap.
        tap_d    = mode_d ? clkdiv[SLOW_TAP] : clkdiv[FAST_TAP];
    end

    // ------------------------------------------------------------------
    // Button debounce (after the 2-FF synchroniser)
    // ------------------------------------------------------------------
    always_comb begin
        db_cnt_d = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                stable_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
        step_pulse_d = stable_d & ~stable_q;
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clk_cpu_d = clk_cpu_q;
        case (state_q)
            ST_HALT: begin
                if (run && !halt_req) begin
                    state_d = ST_RUN;
                end else if (!run && step_pulse_q) begin
                    state_d   = ST_STEP;
                    clk_cpu_d = 1'b1;
                end
            end
            ST_RUN: begin
                // Stop wins over a coincident rise_ev.
                if (halt_req || !run) begin
                    if (!clk_cpu_q) begin
                        state_d = ST_HALT;
                    end else if (fall_ev) begin
                        clk_cpu_d = 1'b0;
                        state_d   = ST_HALT;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (rise_ev) begin
                    clk_cpu_d = 1'b1;
                end else if (fall_ev) begin
                    clk_cpu_d = 1'b0;
                end
            end
            default: begin
                // STEP and DRAIN both finish the current high phase and stop.
                if (fall_ev) begin
                    clk_cpu_d = 1'b0;
                    state_d   = ST_HALT;
                end
            end
        endcase
        tick_d      = clk_cpu_d & ~clk_cpu_q;
        cycle_cnt_d = cycle_cnt_q + {31'd0, tick_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_HALT;
            clk_cpu_q    <= 1'b0;
            tick_q       <= 1'b0;
            cycle_cnt_q  <= '0;
            mode_q       <= 1'b0;
            tap_q        <= 1'b0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            db_cnt_q     <= '0;
            step_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_cpu_q    <= clk_cpu_d;
            tick_q       <= tick_d;
            cycle_cnt_q  <= cycle_cnt_d;
            mode_q       <= mode_d;
            tap_q        <= tap_d;
            sync1_q      <= step_btn;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            db_cnt_q     <= db_cnt_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    assign Clk_CPU   = clk_cpu_q;
    assign cpu_tick  = tick_q;
    assign state     = state_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cpu_clk_ctrl
//   Scoreboard bench for cpu_clk_ctrl. A reference model advances on every
//   clk rising edge and queues the outputs expected after that edge; a monitor
//   pops one entry per falling edge and compares against the DUT.
// ----------------------------------------------------------------------------
module tb_cpu_clk_ctrl;

    localparam int FT = 1;
    localparam int SL = 3;
    localparam int DB = 4;

    localparam int S_HALT  = 0;
    localparam int S_RUN   = 1;
    localparam int S_STEP  = 2;
    localparam int S_DRAIN = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] clkdiv = 32'd0;
    logic        mode_sel = 1'b0;
    logic        run = 1'b0;
    logic        step_btn = 1'b0;
    logic        halt_req = 1'b0;
    wire         Clk_CPU;
    wire         cpu_tick;
    wire  [1:0]  state;
    wire  [31:0] cycle_cnt;

    int errors = 0;
    int checks = 0;

    cpu_clk_ctrl #(.FAST_TAP(FT), .SLOW_TAP(SL), .DB_COUNT(DB)) dut (
        .clk      (clk),
        .rst      (rst),
        .clkdiv   (clkdiv),
        .mode_sel (mode_sel),
        .run      (run),
        .step_btn (step_btn),
        .halt_req (halt_req),
        .Clk_CPU  (Clk_CPU),
        .cpu_tick (cpu_tick),
        .state    (state),
        .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    // Free-running divider, updated well away from the sampling edge.
    initial forever begin
        @(posedge clk);
        #2 clkdiv = clkdiv + 32'd1;
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic        c;
        logic        t;
        logic [1:0]  s;
        logic [31:0] n;
    } exp_t;

    exp_t        expq[$];
    int          m_st = S_HALT;
    bit          m_clk, m_tick, m_mode, m_tapq, m_stable, m_pulse;
    logic [31:0] m_cnt = 32'd0;
    bit          bh[$];   // raw button samples, newest first

    function automatic bit tapbit(bit m, logic [31:0] cd);
        return m ? cd[SL] : cd[FT];
    endfunction

    task automatic model_step();
        bit   tap, rise, fall, pulse, flip, nclk, nmode;
        int   nst;
        exp_t e;
        if (rst) begin
            m_st = S_HALT; m_clk = 0; m_tick = 0; m_cnt = 32'd0;
            m_mode = 0; m_tapq = 0; m_stable = 0; m_pulse = 0;
            bh.delete();
        end else begin
            tap   = tapbit(m_mode, clkdiv);
            rise  = tap && !m_tapq;
            fall  = !tap && m_tapq;
            pulse = m_pulse;

            // Button accepted once its synchronised value (two samples late)
            // has disagreed with the accepted level for DB straight clocks.
            bh.push_front(step_btn);
            if (bh.size() > DB + 2) void'(bh.pop_back());
            flip = 0;
            if (bh.size() == DB + 2) begin
                flip = 1;
                for (int i = 2; i < DB + 2; i++)
                    if (bh[i] == m_stable) flip = 0;
            end
            m_pulse = flip && !m_stable;
            if (flip) m_stable = !m_stable;

            nclk = m_clk;
            nst  = m_st;
            if (m_st == S_HALT) begin
                if (run && !halt_req) nst = S_RUN;
                else if (!run && pulse) begin nst = S_STEP; nclk = 1; end
            end else if (m_st == S_RUN) begin
                if (halt_req || !run) begin
                    if (!m_clk) nst = S_HALT;
                    else if (fall) begin nclk = 0; nst = S_HALT; end
                    else nst = S_DRAIN;
                end else if (rise) nclk = 1;
                else if (fall) nclk = 0;
            end else begin
                if (fall) begin nclk = 0; nst = S_HALT; end
            end

            nmode  = (m_st == S_HALT || (m_st == S_RUN && fall)) ? mode_sel : m_mode;
            m_tapq = (nmode != m_mode) ? tapbit(nmode, clkdiv) : tap;
            m_mode = nmode;
            m_tick = nclk && !m_clk;
            if (m_tick) m_cnt = m_cnt + 32'd1;
            m_clk  = nclk;
            m_st   = nst;
        end
        e.c = m_clk; e.t = m_tick; e.s = 2'(m_st); e.n = m_cnt;
        expq.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("Clk_CPU",   {31'd0, Clk_CPU},  {31'd0, e.c});
            chk("cpu_tick",  {31'd0, cpu_tick}, {31'd0, e.t});
            chk("state",     {30'd0, state},    {30'd0, e.s});
            chk("cycle_cnt", cycle_cnt,         e.n);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_clk_high(string nm);
        int k = 0;
        while (!m_clk && k < 200) begin @(negedge clk); k++; end
        checks++;
        if (k >= 200) begin
            errors++;
            $display("FAIL %s timeout actual=0 expected=1", nm);
        end
    endtask

    task automatic press();
        step_btn = 1; cyc(2);
        step_btn = 0; cyc(2);
        step_btn = 1; cyc(10);
        step_btn = 0; cyc(10);
    endtask

    initial begin
        int k;
        // Reset then free-run, fast tap.
        cyc(3);
        rst = 0; run = 1; mode_sel = 0;
        cyc(30);

        // Halt while Clk_CPU high: drain, hold off, resume.
        wait_clk_high("halt_wait");
        halt_req = 1;
        cyc(12);
        halt_req = 0;
        cyc(12);

        // Halt request coincident with a rise_ev while Clk_CPU is low.
        k = 0;
        while (!(m_st == S_RUN && !m_clk && tapbit(m_mode, clkdiv) && !m_tapq) && k < 200) begin
            cyc(1); k++;
        end
        halt_req = 1;
        cyc(1);
        chk("coll_state", {30'd0, state}, S_HALT);
        chk("coll_clk",   {31'd0, Clk_CPU}, 32'd0);
        cyc(6);
        halt_req = 0;
        cyc(10);

        // Mode switch mid high phase, then back.
        wait_clk_high("mode_wait");
        mode_sel = 1;
        cyc(48);
        mode_sel = 0;
        cyc(40);

        // Step mode, fast tap.
        run = 0;
        cyc(20);
        press();
        cyc(6);

        // Step mode, slow tap, second press while stepping.
        mode_sel = 1;
        cyc(4);
        step_btn = 1; cyc(8);
        step_btn = 0; cyc(1);
        step_btn = 1; cyc(10);
        step_btn = 0; cyc(30);

        // Counter wrap on a step.
        mode_sel = 0;
        cyc(4);
        #2;
        force dut.cycle_cnt_q = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        cyc(2);
        #2;
        release dut.cycle_cnt_q;
        cyc(2);
        press();
        cyc(4);

        // Asynchronous reset while Clk_CPU is high.
        run = 1;
        wait_clk_high("arst_wait");
        #2 rst = 1;
        #1;
        chk("arst_clk",   {31'd0, Clk_CPU}, 32'd0);
        chk("arst_state", {30'd0, state},   S_HALT);
        chk("arst_cnt",   cycle_cnt,        32'd0);
        cyc(3);
        rst = 0;
        cyc(10);

        // Randomised run/halt/mode/button activity.
        repeat (150) begin
            run      = ($urandom_range(0, 3) != 0);
            halt_req = ($urandom_range(0, 5) == 0);
            mode_sel = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 4)) begin
                    step_btn = ~step_btn;
                    cyc($urandom_range(1, 3));
                end
                step_btn = 1;
                cyc($urandom_range(3, 12));
                step_btn = 0;
            end
            cyc($urandom_range(1, 20));
        end

        cyc(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
- Run/step/halt sequencer for the CPU clock.
- Consumes the free-running `clkdiv` counter, picks a fast or slow divider tap, and emits a registered, glitch-free `Clk_CPU`.
- Supports free-run, single-step from a debounced push button, and halt on request. A halt is never allowed to truncate a CPU high phase.
- Sits between the clock divider and the CPU clock input; also reports state and a retired-cycle count to the display/debug logic.

Parameters:
- FAST_TAP, 1, `clkdiv` bit used when mode_sel=0.
- SLOW_TAP, 24, `clkdiv` bit used when mode_sel=1.
- DB_COUNT, 1000000, clk cycles the synchronised button must stay stable before it is accepted (must be ≥2).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- clkdiv  input  32  free-running divider count.
- mode_sel  input  1  0 = fast tap, 1 = slow tap.
- run  input  1  1 = free-run, 0 = step mode.
- step_btn  input  1  raw, asynchronous, bouncing step button.
- halt_req  input  1  level halt request (breakpoint/debug).
- Clk_CPU  output  1  registered CPU clock.
- cpu_tick  output  1  one-clk pulse coincident with each Clk_CPU rising edge.
- state  output  2  0 HALT, 1 RUN, 2 STEP, 3 DRAIN.
- cycle_cnt  output  32  count of Clk_CPU rising edges issued.

Behaviour:
- **Reset values:** one clock `clk`; `rst` is asynchronous and active-high. Reset forces Clk_CPU=0, cpu_tick=0, state=HALT, cycle_cnt=0, mode_r=0, tap_q=0, debouncer cleared (stable=0, counter=0, sync FFs=0). Reset mid-cycle drops Clk_CPU to 0 immediately.
- **Tap selection:**
  - tap = mode_r ? clkdiv[SLOW_TAP] : clkdiv[FAST_TAP].
  - tap_q <= tap every clk.
  - rise_ev = tap & ~tap_q; fall_ev = ~tap & tap_q.
- **Mode latch:** mode_r <= mode_sel only while state==HALT, or in RUN on a clk where fall_ev=1. On the clk mode_r changes, tap_q is loaded with the new tap value, so no event is generated that cycle.
- **Debounce:**
  - step_btn passes through a 2-FF synchroniser.
  - The counter increments while sync != stable and resets to 0 while they are equal.
  - When the counter reaches DB_COUNT-1: stable <= sync, counter <= 0.
  - step_pulse = one-clk pulse on the 0→1 transition of stable.
- **cpu_tick / cycle_cnt:** cpu_tick=1 exactly on the clk where Clk_CPU goes 0→1, otherwise 0. cycle_cnt increments on the same clk and wraps 0xFFFFFFFF→0.
- **HALT** (Clk_CPU held 0):
  - run=1 and halt_req=0 → RUN. No edge is produced on the transition clk; the first rise comes on a later rise_ev.
  - run=0 and step_pulse=1 → STEP; Clk_CPU<=1 on that same edge (tick, count). Allowed regardless of halt_req.
  - step_pulse in any state other than HALT is discarded.
- **RUN:**
  - If halt_req=1 or run=0 (stop has priority over rise_ev on the same clk):
    - Clk_CPU==0 → HALT.
    - Clk_CPU==1 → DRAIN. A fall_ev on that same clk still clears Clk_CPU, and the next state is then HALT.
  - Otherwise: rise_ev → Clk_CPU<=1 (tick, count); fall_ev → Clk_CPU<=0.
- **STEP:**
  - Hold Clk_CPU=1 until fall_ev, then Clk_CPU<=0 and → HALT.
  - halt_req and run changes are ignored until the step completes, so exactly one CPU cycle is issued per press.
- **DRAIN:** hold Clk_CPU=1 until fall_ev, then Clk_CPU<=0 and → HALT. No rise is ever issued in DRAIN.
- **Output timing:** Clk_CPU is always a flop output, with high and low phases each ≥1 clk.

Test Plan:
- **Reset/run:** assert rst for 3 clks; release with run=1, mode_sel=0, FAST_TAP=1 → state HALT, then RUN; Clk_CPU toggles every 2 clk (period 4 clk); cycle_cnt=5 after 5 rises; cpu_tick width 1 clk.
- **Debounce/step:** run=0, DB_COUNT=4; bounce step_btn 1-0-1 with 2-clk gaps, then hold 10 clks → exactly one STEP entry; cycle_cnt +1; Clk_CPU high until next tap fall, then HALT; a second press during STEP adds nothing.
- **Halt while high:** in RUN, assert halt_req while Clk_CPU=1 → state DRAIN; Clk_CPU stays 1 until fall_ev, then 0 and HALT; no further ticks while halt_req=1; release → RUN resumes on the next rise_ev.
- **Halt/rise collision:** halt_req rising on the same clk as rise_ev with Clk_CPU=0 → HALT next clk; Clk_CPU stays 0; cycle_cnt unchanged.
- **Mode switch:** toggle mode_sel mid-high phase in RUN (FAST_TAP=1, SLOW_TAP=3) → switch takes effect only at the next fall_ev; new period 16 clk; no runt pulse shorter than 1 clk.
- **Wrap and async reset:** force cycle_cnt=0xFFFFFFFF, then one step → 0x00000000. Asynchronous rst while Clk_CPU=1 → Clk_CPU=0 before the next clk edge.
